// File: rtl/vector_pkg.sv
// Shared sizing constants and FSM state encoding for the vector operand mux controller.
package vector_pkg;

   localparam int LANES = 8;
   localparam int WIDTH = 32;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/vector_lane_buffer.sv
// LANES x WIDTH register bank: one lane written per cycle by index, whole bank cleared synchronously.
module vector_lane_buffer #(
   parameter int LANES = vector_pkg::LANES,
   parameter int WIDTH = vector_pkg::WIDTH,
   parameter int CNT_W = vector_pkg::CNT_W
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [CNT_W-1:0]             wr_idx,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [LANES-1:0][WIDTH-1:0]  lanes
);

   // NOTE: this bank is flops, not RAM, so a synchronous clear of every lane is
   // cheap and gives the consumer a defined all-zero vector after reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         lanes <= '0;
      end else if (wr_en && (int'(wr_idx) < LANES)) begin
         lanes[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/vector_mux_ctrl.sv
// Operand sequencer for the vector data mux: passes vin lanes through, or assembles a
// vector from a memory word stream into buf lanes, then holds it until consumed.
module vector_mux_ctrl #(
   parameter int LANES = vector_pkg::LANES,
   parameter int WIDTH = vector_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   input  logic             req_src,
   output logic             req_ready,
   input  logic [WIDTH-1:0] mem_data,
   input  logic             mem_valid,
   output logic             mem_ready,
   output logic [WIDTH-1:0] buf1,
   output logic [WIDTH-1:0] buf2,
   output logic [WIDTH-1:0] buf3,
   output logic [WIDTH-1:0] buf4,
   output logic [WIDTH-1:0] buf5,
   output logic [WIDTH-1:0] buf6,
   output logic [WIDTH-1:0] buf7,
   output logic [WIDTH-1:0] buf8,
   output logic             control,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic             busy
);

   import vector_pkg::state_t;
   import vector_pkg::ST_IDLE;
   import vector_pkg::ST_FILL;
   import vector_pkg::ST_HOLD;

   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

   state_t                      state, state_nxt;
   logic [CNT_W-1:0]            cnt, cnt_nxt;
   logic                        control_nxt;
   logic                        buf_we;
   logic [LANES-1:0][WIDTH-1:0] bank;
   logic [7:0][WIDTH-1:0]       lanes8;

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      control_nxt = control;
      buf_we      = 1'b0;
      if (flush) begin
         // Abort wins over a coincident final beat or consume; buffers keep contents.
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  control_nxt = req_src;
                  cnt_nxt     = '0;
                  state_nxt   = req_src ? ST_FILL : ST_HOLD;
               end
            end
            ST_FILL: begin
               if (mem_valid) begin
                  buf_we = 1'b1;
                  if (cnt == CNT_LAST) begin
                     cnt_nxt   = '0;
                     state_nxt = ST_HOLD;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (vec_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         control <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         control <= control_nxt;
      end
   end

   vector_lane_buffer #(
      .LANES (LANES),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_lane_buffer (
      .clk     (clk),
      .clr     (rst),
      .wr_en   (buf_we),
      .wr_idx  (cnt),
      .wr_data (mem_data),
      .lanes   (bank)
   );

   // Eight fixed output lanes; lanes beyond LANES read as zero.
   for (genvar i = 0; i < 8; i++) begin : g_lane_out
      if (i < LANES) begin : g_used
         assign lanes8[i] = bank[i];
      end else begin : g_unused
         assign lanes8[i] = '0;
      end
   end

   assign {buf8, buf7, buf6, buf5, buf4, buf3, buf2, buf1} = lanes8;

   assign req_ready = (state == ST_IDLE);
   assign mem_ready = (state == ST_FILL);
   assign vec_valid = (state == ST_HOLD);
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_vector_mux_ctrl.sv
// Scoreboard bench for vector_mux_ctrl: expected operands queued at request time, compared on vec_valid.
module tb_vector_mux_ctrl;

   localparam int LANES = 8;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst, flush, req_valid, req_src, mem_valid, vec_ready;
   logic [WIDTH-1:0] mem_data;
   logic             req_ready, mem_ready, control, vec_valid, busy;
   logic [WIDTH-1:0] buf1, buf2, buf3, buf4, buf5, buf6, buf7, buf8;
   logic [7:0][WIDTH-1:0] bufs;

   typedef struct packed {
      logic                  ctl;
      logic [7:0][WIDTH-1:0] lanes;
   } exp_t;

   exp_t                  sb[$];
   logic [7:0][WIDTH-1:0] model_bufs;
   int                    checks = 0;
   int                    failures = 0;
   int                    cycle = 0;

   vector_mux_ctrl #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_src   (req_src),
      .req_ready (req_ready),
      .mem_data  (mem_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .buf1      (buf1),
      .buf2      (buf2),
      .buf3      (buf3),
      .buf4      (buf4),
      .buf5      (buf5),
      .buf6      (buf6),
      .buf7      (buf7),
      .buf8      (buf8),
      .control   (control),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .busy      (busy)
   );

   assign bufs = {buf8, buf7, buf6, buf5, buf4, buf3, buf2, buf1};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic check_reset_state(input string pfx);
      for (int i = 0; i < 8; i++) check($sformatf("%s_buf%0d", pfx, i + 1), bufs[i], '0);
      check({pfx, "_control"},   control,   1'b0);
      check({pfx, "_vec_valid"}, vec_valid, 1'b0);
      check({pfx, "_req_ready"}, req_ready, 1'b1);
      check({pfx, "_mem_ready"}, mem_ready, 1'b0);
      check({pfx, "_busy"},      busy,      1'b0);
   endtask

   // Waits (bounded) for vec_valid, then pops and compares the oldest expected operand.
   task automatic collect(input string pfx);
      exp_t e;
      int   n = 0;
      while (vec_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({pfx, "_vec_valid_seen"}, vec_valid, 1'b1);
      if (sb.size() == 0) begin
         check({pfx, "_sb_nonempty"}, 1'b0, 1'b1);
      end else begin
         e = sb.pop_front();
         check({pfx, "_control"}, control, e.ctl);
         for (int i = 0; i < 8; i++) check($sformatf("%s_buf%0d", pfx, i + 1), bufs[i], e.lanes[i]);
      end
   endtask

   task automatic consume(input string pfx);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      check({pfx, "_idle_vec_valid"}, vec_valid, 1'b0);
      check({pfx, "_idle_req_ready"}, req_ready, 1'b1);
   endtask

   // Memory-sourced request: LANES beats of base+k, optional stall after beat stall_after.
   task automatic fill(input string pfx, input logic [WIDTH-1:0] base, input int stall_after, input int stall_len);
      exp_t e;
      int   t0;
      t0 = cycle;
      req_valid = 1'b1;
      req_src   = 1'b1;
      tick();
      req_valid = 1'b0;
      check({pfx, "_mem_ready"}, mem_ready, 1'b1);
      check({pfx, "_control"},   control,   1'b1);
      for (int k = 0; k < LANES; k++) model_bufs[k] = base + WIDTH'(k);
      e.ctl   = 1'b1;
      e.lanes = model_bufs;
      sb.push_back(e);
      for (int k = 0; k < LANES; k++) begin
         mem_valid = 1'b1;
         mem_data  = base + WIDTH'(k);
         tick();
         if (k == stall_after - 1) begin
            mem_valid = 1'b0;
            mem_data  = 32'hdead_beef;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               check({pfx, "_stall_no_vec"}, vec_valid, 1'b0);
            end
         end
      end
      mem_valid = 1'b0;
      check({pfx, "_vec_valid_on_time"}, vec_valid, 1'b1);
      check({pfx, "_latency"}, WIDTH'(cycle - t0), WIDTH'(1 + LANES + stall_len));
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_src = 1'b0;
      mem_valid = 1'b0; mem_data = '0; vec_ready = 1'b0;
      model_bufs = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_reset_state("reset");

      // vec_ready in IDLE has no effect.
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      check("idle_vec_ready_busy", busy, 1'b0);

      // Register-file source: one-cycle latency, buffers untouched.
      req_valid = 1'b1;
      req_src   = 1'b0;
      e.ctl     = 1'b0;
      e.lanes   = model_bufs;
      sb.push_back(e);
      tick();
      check("vin_vec_valid", vec_valid, 1'b1);
      check("vin_busy",      busy,      1'b1);
      // Request held high in HOLD must be ignored.
      req_src = 1'b1;
      tick();
      req_valid = 1'b0;
      check("vin_hold_control", control,   1'b0);
      check("vin_hold_mem_rdy", mem_ready, 1'b0);
      tick();
      collect("vin");
      consume("vin");

      // Memory stream, no stall, then with a 3-cycle stall after beat 4.
      fill("mem", 32'd9, 0, 0);
      collect("mem");
      consume("mem");
      tick();
      fill("stall", 32'd9, 4, 3);
      collect("stall");
      consume("stall");

      // Flush coincident with beat 5 after a reset clears the buffers.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_bufs = '0;
      req_valid = 1'b1;
      req_src   = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_valid = 1'b1;
         mem_data  = 32'd9 + WIDTH'(k);
         model_bufs[k] = mem_data;
         tick();
      end
      mem_data = 32'd13;
      flush    = 1'b1;
      tick();
      flush     = 1'b0;
      mem_valid = 1'b0;
      check("flush_req_ready", req_ready, 1'b1);
      check("flush_vec_valid", vec_valid, 1'b0);
      check("flush_control",   control,   1'b1);
      for (int i = 0; i < 8; i++) check($sformatf("flush_buf%0d", i + 1), bufs[i], model_bufs[i]);
      tick();
      check("flush_no_vec", vec_valid, 1'b0);
      fill("restart", 32'd100, 0, 0);
      collect("restart");

      // Flush together with vec_ready in HOLD: IDLE, control and buffers kept.
      flush     = 1'b1;
      vec_ready = 1'b1;
      tick();
      flush     = 1'b0;
      vec_ready = 1'b0;
      check("flush_hold_vec_valid", vec_valid, 1'b0);
      check("flush_hold_control",   control,   1'b1);
      check("flush_hold_buf8",      buf8,      32'd107);
      tick();

      // Reset while holding, with a competing request that must never be taken.
      fill("rsthold", 32'd200, 0, 0);
      collect("rsthold");
      req_valid = 1'b1;
      req_src   = 1'b0;
      tick();
      check("rsthold_req_ignored", control, 1'b1);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      req_valid = 1'b0;
      check_reset_state("rsthold");
      tick();
      check("rsthold_no_vec", vec_valid, 1'b0);
      check("sb_drained", WIDTH'(sb.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
